// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz raster constants shared by the timing generator,
// the rectangle comparators and the renderer. Sync windows are half-open [start, end).
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // 10-bit forms used directly by the counter compare logic
  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);

  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);

  // True when lo <= x < hi
  function automatic logic in_window(input logic [9:0] x, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/clk_enable_div.sv
// clk_enable_div: free-running divider producing a one-clock enable every CLK_DIV clocks.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset, clears the divider to 0
//   tick  - high while the divider sits at CLK_DIV-1 (always high when CLK_DIV is 1)
// CLK_DIV legal range is 1..16 (4-bit divider).
module clk_enable_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);

  logic [3:0] div_q, div_d;

  always_comb begin
    div_d = div_q + 4'd1;
    if (div_q == DIV_MAX) div_d = 4'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_q <= 4'd0;
    else       div_q <= div_d;
  end

  // Decoded from the registered count so tick is glitch-free and a full period after reset
  assign tick = (div_q == DIV_MAX);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz raster scan generator.
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-high reset
//   pixel_tick  - one-clock enable; counters advance on the edge where it is high
//   h_count     - horizontal position 0..799
//   v_count     - vertical position 0..524
//   hsync/vsync - registered sync pulses, SYNC_ACTIVE level while in the sync window
//   video_on    - registered, high inside the 640x480 visible area
//   frame_start - one-clock pulse after the counters wrap to (0,0)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_tick,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  logic [9:0] h_count_q, h_count_d;
  logic [9:0] v_count_q, v_count_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_wrap;

  clk_enable_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_div (
    .clk  (clk),
    .reset(reset),
    .tick (pixel_tick)
  );

  always_comb begin
    h_count_d  = h_count_q;
    v_count_d  = v_count_q;
    frame_wrap = 1'b0;
    if (pixel_tick) begin
      if (h_count_q == H_MAX) begin
        h_count_d = 10'd0;
        if (v_count_q == V_MAX) begin
          v_count_d  = 10'd0;
          frame_wrap = 1'b1;
        end else begin
          v_count_d = v_count_q + 10'd1;
        end
      end else begin
        h_count_d = h_count_q + 10'd1;
      end
    end
  end

  // Flags are decoded from the next counts so they change on the same edge as the counters
  always_comb begin
    hsync_d    = in_window(h_count_d, H_SYNC_START, H_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d    = in_window(v_count_d, V_SYNC_START, V_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    video_on_d = (h_count_d < H_VIS_END) && (v_count_d < V_VIS_END);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count_q     <= 10'd0;
      v_count_q     <= 10'd0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_wrap;
    end
  end

  assign h_count     = h_count_q;
  assign v_count     = v_count_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default instance (CLK_DIV=4, active-low sync) and one fast
// instance (CLK_DIV=1, active-high sync). Reaching deep raster positions uses a brief
// force/release of the internal counters; the reference model is then moved to the same spot.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       pt_a, hs_a, vs_a, vo_a, fs_a;
  logic       pt_b, hs_b, vs_b, vo_b, fs_b;
  logic [9:0] h_a, v_a, h_b, v_b;
  logic [9:0] jh, jv;

  vga_timing_gen #(.CLK_DIV(4), .SYNC_ACTIVE(1'b0)) dut_a (
    .clk(clk), .reset(rst_a), .pixel_tick(pt_a), .h_count(h_a), .v_count(v_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(vo_a), .frame_start(fs_a)
  );

  vga_timing_gen #(.CLK_DIV(1), .SYNC_ACTIVE(1'b1)) dut_b (
    .clk(clk), .reset(rst_b), .pixel_tick(pt_b), .h_count(h_b), .v_count(v_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(vo_b), .frame_start(fs_b)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: raster position as plain integers, advanced every CLK_DIV edges
  int unsigned m_div [2] = '{4, 1};
  logic        m_sa  [2] = '{1'b0, 1'b1};
  bit          m_rst [2];
  bit          m_adv [2];
  bit          m_fs  [2];
  int unsigned m_edges [2];
  int unsigned m_h [2];
  int unsigned m_v [2];

  function automatic logic [24:0] obs(input int i);
    if (i == 0) return {pt_a, h_a, v_a, hs_a, vs_a, vo_a, fs_a};
    return {pt_b, h_b, v_b, hs_b, vs_b, vo_b, fs_b};
  endfunction

  function automatic logic [24:0] exp_vec(input int i);
    logic pt, hs, vs, vo;
    if (m_rst[i]) pt = (m_div[i] == 1);
    else          pt = ((m_edges[i] % m_div[i]) == m_div[i] - 1);
    hs = (m_h[i] >= 656 && m_h[i] < 752) ? m_sa[i] : ~m_sa[i];
    vs = (m_v[i] >= 490 && m_v[i] < 492) ? m_sa[i] : ~m_sa[i];
    vo = (m_h[i] < 640) && (m_v[i] < 480);
    return {pt, 10'(m_h[i]), 10'(m_v[i]), hs, vs, vo, m_fs[i]};
  endfunction

  task automatic model_reset(input int i);
    m_rst[i] = 1'b1; m_edges[i] = 0; m_h[i] = 0; m_v[i] = 0; m_fs[i] = 1'b0; m_adv[i] = 1'b0;
  endtask

  // One rising edge for both models, then return at the falling edge for sampling
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_adv[i] = 1'b0;
      if (!m_rst[i]) begin
        m_edges[i]++;
        m_fs[i] = 1'b0;
        if (m_edges[i] % m_div[i] == 0) begin
          m_adv[i] = 1'b1;
          if (m_h[i] == 799) begin
            m_h[i] = 0;
            if (m_v[i] == 524) begin
              m_v[i] = 0;
              m_fs[i] = 1'b1;
            end else begin
              m_v[i]++;
            end
          end else begin
            m_h[i]++;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  // Deposit (h,v) mid-cycle, then run until one advance has refreshed the registered flags
  task automatic jump(input int i, input int h, input int v);
    jh = 10'(h);
    jv = 10'(v);
    #1;
    if (i == 0) begin force dut_a.h_count_q = jh; force dut_a.v_count_q = jv; end
    else        begin force dut_b.h_count_q = jh; force dut_b.v_count_q = jv; end
    #1;
    if (i == 0) begin release dut_a.h_count_q; release dut_a.v_count_q; end
    else        begin release dut_b.h_count_q; release dut_b.v_count_q; end
    m_h[i] = h;
    m_v[i] = v;
    do step(); while (!m_adv[i]);
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    model_reset(0);
    repeat (3) begin
      step();
      checks++;
      if (obs(0) !== exp_vec(0)) begin
        failures++;
        $display("FAIL reset_hold got=%h exp=%h", obs(0), exp_vec(0));
      end
    end
    rst_a = 1'b0;
    m_rst[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (obs(0) !== exp_vec(0)) begin
        failures++;
        $display("FAIL reset_release edge=%0d got=%h exp=%h", k, obs(0), exp_vec(0));
      end
    end
    checks++;
    if (h_a !== 10'd1) begin
      failures++;
      $display("FAIL first_advance h_count got=%0d exp=1", h_a);
    end
  endtask

  task automatic test_hsync();
    logic prev_hs, prev_vo;
    int h_fall = -1;
    int h_rise = -1;
    int vo_fall = -1;
    int low_ticks = 0;
    prev_hs = hs_a;
    prev_vo = vo_a;
    while (m_h[0] != 760) begin
      step();
      checks++;
      if (obs(0) !== exp_vec(0)) begin
        failures++;
        $display("FAIL hsync_scan got=%h exp=%h", obs(0), exp_vec(0));
      end
      if (prev_hs && !hs_a) h_fall = int'(h_a);
      if (!prev_hs && hs_a) h_rise = int'(h_a);
      if (prev_vo && !vo_a) vo_fall = int'(h_a);
      if (m_adv[0] && !hs_a) low_ticks++;
      prev_hs = hs_a;
      prev_vo = vo_a;
    end
    checks++;
    if (h_fall != 656 || h_rise != 752) begin
      failures++;
      $display("FAIL hsync_edges got fall=%0d rise=%0d exp fall=656 rise=752", h_fall, h_rise);
    end
    checks++;
    if (low_ticks != 96) begin
      failures++;
      $display("FAIL hsync_width got=%0d exp=96", low_ticks);
    end
    checks++;
    if (vo_fall != 640) begin
      failures++;
      $display("FAIL video_on_fall got=%0d exp=640", vo_fall);
    end
  endtask

  task automatic test_line_wrap();
    int cnt = 0;
    jump(0, 797, 10);
    while (m_h[0] != 799) step();
    do begin
      step();
      checks++;
      if (obs(0) !== exp_vec(0)) begin
        failures++;
        $display("FAIL line_wrap_scan got=%h exp=%h", obs(0), exp_vec(0));
      end
    end while (!m_adv[0]);
    checks++;
    if (h_a !== 10'd0 || v_a !== 10'd11) begin
      failures++;
      $display("FAIL line_wrap got=(%0d,%0d) exp=(0,11)", h_a, v_a);
    end
    // Clocks from (0,11) until the next line starts at (0,12)
    while (!(h_a == 10'd0 && v_a == 10'd12) && cnt < 4000) begin
      step();
      cnt++;
    end
    checks++;
    if (cnt != 3200) begin
      failures++;
      $display("FAIL line_period got=%0d exp=3200", cnt);
    end
  endtask

  task automatic test_frame_wrap();
    int waited = 0;
    int fs_clocks = 0;
    jump(0, 797, 524);
    while (!fs_a && waited < 20) begin
      step();
      waited++;
      checks++;
      if (obs(0) !== exp_vec(0)) begin
        failures++;
        $display("FAIL frame_wrap_scan got=%h exp=%h", obs(0), exp_vec(0));
      end
    end
    checks++;
    if (fs_a !== 1'b1 || h_a !== 10'd0 || v_a !== 10'd0) begin
      failures++;
      $display("FAIL frame_wrap got=(%0d,%0d) fs=%b exp=(0,0) fs=1", h_a, v_a, fs_a);
    end
    fs_clocks = int'(fs_a);
    repeat (8) begin
      step();
      fs_clocks += int'(fs_a);
      checks++;
      if (obs(0) !== exp_vec(0)) begin
        failures++;
        $display("FAIL frame_after got=%h exp=%h", obs(0), exp_vec(0));
      end
    end
    checks++;
    if (fs_clocks != 1) begin
      failures++;
      $display("FAIL frame_start_width got=%0d exp=1", fs_clocks);
    end
  endtask

  task automatic test_vsync();
    int v_lo = 1000;
    int v_hi = -1;
    int vo_bad = 0;
    jump(0, 797, 487);
    while (m_v[0] != 493) begin
      step();
      checks++;
      if (obs(0) !== exp_vec(0)) begin
        failures++;
        $display("FAIL vsync_scan got=%h exp=%h", obs(0), exp_vec(0));
      end
      if (!vs_a) begin
        if (int'(v_a) < v_lo) v_lo = int'(v_a);
        if (int'(v_a) > v_hi) v_hi = int'(v_a);
      end
      if (vo_a) vo_bad++;
    end
    checks++;
    if (v_lo != 490 || v_hi != 491) begin
      failures++;
      $display("FAIL vsync_lines got=%0d..%0d exp=490..491", v_lo, v_hi);
    end
    checks++;
    if (vo_bad != 0) begin
      failures++;
      $display("FAIL video_on_vblank got=%0d exp=0", vo_bad);
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      jump(0, int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
      n = int'($urandom_range(40, 600));
      repeat (n) begin
        step();
        checks++;
        if (obs(0) !== exp_vec(0)) begin
          failures++;
          $display("FAIL random_scan r=%0d got=%h exp=%h", r, obs(0), exp_vec(0));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    // (300,200) in visible area, then (700,491) with both syncs active
    for (int s = 0; s < 2; s++) begin
      if (s == 0) jump(0, 299, 200);
      else        jump(0, 699, 491);
      #2;
      rst_a = 1'b1;
      model_reset(0);
      #1;
      checks++;
      if (obs(0) !== exp_vec(0)) begin
        failures++;
        $display("FAIL async_reset s=%0d got=%h exp=%h", s, obs(0), exp_vec(0));
      end
      step();
      rst_a = 1'b0;
      m_rst[0] = 1'b0;
      repeat (4) begin
        step();
        checks++;
        if (obs(0) !== exp_vec(0)) begin
          failures++;
          $display("FAIL reset_mid_release s=%0d got=%h exp=%h", s, obs(0), exp_vec(0));
        end
      end
      checks++;
      if (h_a !== 10'd1 || v_a !== 10'd0) begin
        failures++;
        $display("FAIL reset_mid_advance got=(%0d,%0d) exp=(1,0)", h_a, v_a);
      end
    end
  endtask

  task automatic test_fast_variant();
    rst_a = 1'b1;
    model_reset(0);
    step();
    checks++;
    if (obs(1) !== exp_vec(1)) begin
      failures++;
      $display("FAIL fast_reset got=%h exp=%h", obs(1), exp_vec(1));
    end
    rst_b = 1'b0;
    m_rst[1] = 1'b0;
    step();
    checks++;
    if (h_b !== 10'd1) begin
      failures++;
      $display("FAIL fast_first_advance got=%0d exp=1", h_b);
    end
    repeat (820) begin
      step();
      checks++;
      if (obs(1) !== exp_vec(1)) begin
        failures++;
        $display("FAIL fast_line got=%h exp=%h", obs(1), exp_vec(1));
      end
    end
    jump(1, 797, 489);
    while (m_v[1] != 492) begin
      step();
      checks++;
      if (obs(1) !== exp_vec(1)) begin
        failures++;
        $display("FAIL fast_vsync got=%h exp=%h", obs(1), exp_vec(1));
      end
    end
    jump(1, 797, 524);
    repeat (6) begin
      step();
      checks++;
      if (obs(1) !== exp_vec(1)) begin
        failures++;
        $display("FAIL fast_frame got=%h exp=%h", obs(1), exp_vec(1));
      end
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    jh = 10'd0;
    jv = 10'd0;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    test_reset();
    test_hsync();
    test_line_wrap();
    test_frame_wrap();
    test_vsync();
    test_random();
    test_reset_mid();
    test_fast_variant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Produces the raster scan that the display comparators and the Pong renderer consume. It divides the system clock into a pixel-rate enable and runs the horizontal and vertical position counters (`h_count`, `v_count`) for 640x480@60 Hz. It also drives the monitor sync pulses, a visible-area flag and a start-of-frame strobe. It sits at the root of the video path: every rectangle comparator, the colour mux and the VGA pins hang off its outputs.

## Interface
- `CLK_DIV`, 4: system clocks per pixel (100 MHz → 25 MHz); legal range 1..16.
- `SYNC_ACTIVE`, 0: level driven on `hsync`/`vsync` during the sync pulse; the inactive level is its complement.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `pixel_tick`  out  1  high for one `clk` when the counters advance at the next edge.
- `h_count`  out  10  horizontal position, 0..799.
- `v_count`  out  10  vertical position, 0..524.
- `hsync`  out  1  horizontal sync, registered.
- `vsync`  out  1  vertical sync, registered.
- `video_on`  out  1  high iff `h_count<640` and `v_count<480`; registered.
- `frame_start`  out  1  one-`clk` pulse when the counters have just wrapped to (0,0).

## Operation
- Horizontal timing: visible 640, front porch 16, sync 96, back porch 48, total 800.
- Vertical timing: visible 480, front porch 10, sync 2, back porch 33, total 525.
- Divider:
  - `div` counts 0..CLK_DIV-1 on every `clk`.
  - `pixel_tick = (div == CLK_DIV-1)`, decoded from the registered `div`.
  - With CLK_DIV=1, `pixel_tick` is constantly high out of reset.
- Counter update, only on an edge where `pixel_tick` is high:
  - `h_count` increments.
  - At 799, `h_count` wraps to 0 and `v_count` increments.
  - At `v_count`=524 with `h_count`=799, both wrap to 0.
  - Counters never reach 800 or 525.
- Registered outputs are computed from the next count values, so on any edge they always agree with the `h_count`/`v_count` being presented:
  - `hsync` = SYNC_ACTIVE iff `h_count` is in [656,752).
  - `vsync` = SYNC_ACTIVE iff `v_count` is in [490,492).
  - `video_on` as defined in the Interface.
- `frame_start` is asserted on the edge where the counters wrap (524,799)→(0,0) and cleared on the next `clk`. It is never asserted by reset.
- Reset values:
  - `div`=0, `h_count`=0, `v_count`=0.
  - `hsync` and `vsync` inactive (~SYNC_ACTIVE).
  - `video_on`=1, consistent with (0,0).
  - `frame_start`=0.
  - `pixel_tick`=0, or 1 if CLK_DIV=1.
- Reset mid-frame: all outputs go to their reset values asynchronously. The first count advance comes CLK_DIV edges after reset deassertion. No partial sync pulse is stretched or completed.
- Width rules: all counters are unsigned. Comparisons are on 10-bit values. The divider is 4 bits wide.

## Timing
- No input handshake; the block is free-running.
- Latency from a `pixel_tick` edge to updated counts and flags: 0 extra cycles, because they update on that edge.
- `pixel_tick` period is CLK_DIV clocks. One line is 800·CLK_DIV clocks. One frame is 420000·CLK_DIV clocks (1,680,000 at defaults).
- Pulse widths: `hsync` active for 96 ticks; `vsync` active for 2 lines (1600 ticks).
- Downstream comparators sample `h_count`/`v_count` combinationally and register on `pixel_tick`, so their result is one pixel later than the counts. Renderers compensate for this; this block adds no delay.

## Structure
- `vga_timing_pkg` holds:
  - H_VISIBLE, H_FP, H_SYNC, H_BP, H_TOTAL.
  - V_VISIBLE, V_FP, V_SYNC, V_BP, V_TOTAL.
  - The derived sync start/end constants.
  - These are shared with the renderer and comparator users; no literals in RTL.
- Sub-module `clk_enable_div`, parameterised by CLK_DIV, produces `pixel_tick`. It is reused by the paddle/ball update logic.

## Test plan
- Reset: hold `reset` high for 3 clocks, then release.
  - During reset: (0,0), `hsync`=`vsync`=1, `video_on`=1, `frame_start`=0.
  - After release: first `h_count`=1 appears on the 4th rising edge.
- Horizontal sync: `hsync` falls on the edge where `h_count` becomes 656 and rises where it becomes 752 (96 ticks); `video_on` falls when `h_count` becomes 640.
- Line wrap: at (799,10) the next tick gives (0,11).
- Frame wrap: at (799,524) the next tick gives (0,0) with `frame_start` high exactly 1 clock; the frame measures 1,680,000 clocks between `frame_start` pulses.
- Vertical sync: `vsync` is low exactly while `v_count` is 490..491; `video_on` stays 0 for `v_count` ≥480.
- Reset mid-frame and variants:
  - Assert `reset` asynchronously at (300,200) between edges → outputs return to reset values without waiting for a clock.
  - Rerun with CLK_DIV=1 and SYNC_ACTIVE=1: counts advance every clock and sync pulses are high.
